// File: rtl/sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// sub_bytes_iter
//
// Sequential AES SubBytes engine. A state of NB bytes is accepted through a
// valid/ready handshake, substituted LANES bytes per cycle (forward or inverse
// S-box, chosen per block by in_inv), and returned through a second
// valid/ready handshake. It trades latency (NB/LANES cycles) for S-box count.
//
// This file also carries the sbox and inv_sbox leaf modules used by the lanes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   input block offered
//   in_ready   engine idle and able to accept a block
//   in_data    input state, byte k = in_data[8k+7:8k]
//   in_inv     mode sampled with in_data: 0 = forward, 1 = inverse S-box
//   out_valid  result available (registered)
//   out_ready  downstream accepts the result
//   out_data   substituted state, same byte ordering as in_data (registered)
//   busy       high while substitution is in progress
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// sbox: forward AES S-box, y = affine(a^-1) in GF(2^8) mod x^8+x^4+x^3+x+1.
// Ports: a = input byte, y = substituted byte.
// -----------------------------------------------------------------------------
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; it also maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8];
    return r ^ 8'h63;
  endfunction

  assign y = affine(ginv(a));

endmodule

// -----------------------------------------------------------------------------
// inv_sbox: inverse AES S-box, y = (inverse_affine(a))^-1.
// Ports: a = input byte, y = substituted byte.
// -----------------------------------------------------------------------------
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    return r ^ 8'h05;
  endfunction

  assign y = ginv(inv_affine(a));

endmodule

// -----------------------------------------------------------------------------
// sub_bytes_iter top
// -----------------------------------------------------------------------------
module sub_bytes_iter #(
  parameter int NB    = 16,
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*NB-1:0] in_data,
  input  logic            in_inv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*NB-1:0] out_data,
  output logic            busy
);

  localparam int ITER  = NB / LANES;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int GRP_W = 8 * LANES;

  if ((LANES < 1) || (NB % LANES != 0)) begin : g_param_err
    $error("sub_bytes_iter: LANES must be a positive divisor of NB");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       st;
  // Group g holds bytes g*LANES .. g*LANES+LANES-1, so the packed layout
  // matches in_data/out_data byte ordering exactly.
  logic [ITER-1:0][GRP_W-1:0]   state_q;
  logic [CNT_W-1:0]             cnt;
  logic                         mode_q;
  logic [GRP_W-1:0]             grp_cur;
  logic [GRP_W-1:0]             grp_sub;

  // Select the group addressed by the counter.
  always_comb begin
    grp_cur = state_q[0];
    for (int g = 0; g < ITER; g++)
      if (cnt == CNT_W'(g)) grp_cur = state_q[g];
  end

  // S-box lanes: both directions are built; the block's mode picks one.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] fwd_y;
    logic [7:0] inv_y;

    sbox u_sbox (
      .a (grp_cur[8*l +: 8]),
      .y (fwd_y)
    );

    inv_sbox u_inv_sbox (
      .a (grp_cur[8*l +: 8]),
      .y (inv_y)
    );

    assign grp_sub[8*l +: 8] = mode_q ? inv_y : fwd_y;
  end

  // Control FSM, state register and handshake output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      state_q   <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_data;
            mode_q  <= in_inv;
            cnt     <= '0;
            st      <= BUSY;
          end
        end
        BUSY: begin
          for (int g = 0; g < ITER; g++)
            if (cnt == CNT_W'(g)) state_q[g] <= grp_sub;
          if (cnt == CNT_W'(ITER - 1)) begin
            cnt       <= '0;
            st        <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Result holds until the consumer takes it; nothing else can
          // enter until then.
          if (out_ready) begin
            out_valid <= 1'b0;
            st        <= IDLE;
          end
        end
        default: begin
          st        <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Decoded from the FSM register only.
  assign in_ready = (st == IDLE);
  assign busy     = (st == BUSY);
  assign out_data = state_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
module tb_sub_bytes_iter;

  localparam int NI = 5;   // instances with LANES = 1,2,4,8,16
  localparam int MI = 2;   // main instance, LANES = 4

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_ready;
  logic [NI-1:0] irdy;
  logic [NI-1:0] ov;
  logic [NI-1:0] bsy;
  logic [127:0]  od [NI];

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sub_bytes_iter #(.NB(16), .LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (irdy[g]),
      .in_data   (in_data),
      .in_inv    (in_inv),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g]),
      .busy      (bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] sub_ref(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = inv ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
    return r;
  endfunction

  task automatic init_tables();
    logic [127:0] rows [16];
    rows = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        fwd_t[16*r + c] = rows[r][127 - 8*c -: 8];
        inv_t[rows[r][127 - 8*c -: 8]] = 8'(16*r + c);
      end
  endtask

  // One block through every instance with out_ready high: checks latency,
  // busy length and result per LANES value.
  task automatic run_one(input string tag, input logic [127:0] din, input logic inv,
                         input logic [127:0] exp);
    int           lat  [NI];
    int           bcnt [NI];
    logic [127:0] got  [NI];
    for (int g = 0; g < NI; g++) begin
      lat[g] = -1; bcnt[g] = 0; got[g] = '0;
    end
    in_valid  = 1'b1;
    in_data   = din;
    in_inv    = inv;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      for (int g = 0; g < NI; g++) begin
        if (bsy[g]) bcnt[g]++;
        if (ov[g] && lat[g] < 0) begin
          lat[g] = k;
          got[g] = od[g];
        end
      end
      tick();
    end
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("%s_lat_L%0d", tag, 1 << g), 128'(lat[g]), 128'(16 >> g));
      chk($sformatf("%s_busy_L%0d", tag, 1 << g), 128'(bcnt[g]), 128'(16 >> g));
      chk($sformatf("%s_data_L%0d", tag, 1 << g), got[g], exp);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
  endtask

  localparam logic [127:0] PT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] S63 = {16{8'h63}};

  initial begin
    logic [127:0] q [$];
    logic [127:0] blk;
    logic         m;
    int           n_sent, n_recv, last;

    init_tables();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 128'(irdy[MI]), 128'(1));
    chk("rst_out_valid", 128'(ov[MI]), 128'(0));
    chk("rst_out_data", od[MI], 128'(0));
    chk("rst_busy", 128'(bsy[MI]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Hand-computed vectors across all LANES values.
    run_one("fips_fwd", PT, 1'b0, SB);
    run_one("fips_inv", SB, 1'b1, PT);
    run_one("zero_fwd", 128'(0), 1'b0, S63);
    run_one("s63_inv", S63, 1'b1, 128'(0));

    // Backpressure: result held 10 cycles, a new offer is not absorbed.
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = PT;
    in_inv    = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_valid_rise", 128'(ov[MI]), 128'(1));
    in_valid = 1'b1;
    in_data  = S63;
    in_inv   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("bp_hold_valid_%0d", k), 128'(ov[MI]), 128'(1));
      chk($sformatf("bp_hold_data_%0d", k), od[MI], SB);
      chk($sformatf("bp_hold_ready_%0d", k), 128'(irdy[MI]), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_xfer_valid", 128'(ov[MI]), 128'(0));
    chk("bp_xfer_ready", 128'(irdy[MI]), 128'(1));
    chk("bp_xfer_busy", 128'(bsy[MI]), 128'(0));
    chk("bp_xfer_data", od[MI], SB);

    // Reset asserted in the second BUSY cycle.
    drain();
    in_valid = 1'b1;
    in_data  = PT;
    in_inv   = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_busy", 128'(bsy[MI]), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(irdy[MI]), 128'(1));
    chk("mid_rst_out_valid", 128'(ov[MI]), 128'(0));
    chk("mid_rst_out_data", od[MI], 128'(0));
    chk("mid_rst_busy", 128'(bsy[MI]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_one("post_rst", SB, 1'b1, PT);

    // Back-to-back random stream on the main instance.
    drain();
    n_sent = 0;
    n_recv = 0;
    last   = -1;
    for (int c = 0; c < 600 && n_recv < 50; c++) begin
      if (ov[MI]) begin
        if (q.size() > 0) chk($sformatf("b2b_data_%0d", n_recv), od[MI], q.pop_front());
        if (last >= 0) chk($sformatf("b2b_gap_%0d", n_recv), 128'(c - last), 128'(6));
        last = c;
        n_recv++;
      end
      if (irdy[MI] && n_sent < 50) begin
        blk = {$urandom, $urandom, $urandom, $urandom};
        m   = 1'($urandom_range(0, 1));
        in_data  = blk;
        in_inv   = m;
        in_valid = 1'b1;
        q.push_back(sub_ref(blk, m));
        n_sent++;
      end else if (n_sent == 50) begin
        in_valid = 1'b0;
      end
      tick();
    end
    chk("b2b_count", 128'(n_recv), 128'(50));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
